// File: rtl/adder_arb_pkg.sv
// Shared widths, result payload and arithmetic helpers for the shared-adder arbiter.
package adder_arb_pkg;

    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned WIDTH = 11;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDW   = id_width(NREQ);

    // Signed overflow: operands agree in sign but the sum does not.
    function automatic logic add_ovf(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } result_t;

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester and response handshake bundle for adder_arbiter.
interface adder_arbiter_if;
    import adder_arb_pkg::*;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic                  rsp_overflow;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant: first request at or above ptr, wrapping, via a doubled request vector.
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int unsigned NREQ  = 4,
    localparam int unsigned ARB_W = id_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [ARB_W-1:0] ptr,
    input  logic             en,
    output logic [NREQ-1:0]  gnt,
    output logic [ARB_W-1:0] gnt_id
);

    logic [2*NREQ-1:0] dbl_c;
    logic [2*NREQ-1:0] masked_c;
    logic              hit_c;

    // Lower copy masked below ptr; upper copy supplies the wrapped-around requests.
    always_comb begin
        dbl_c    = {req, req};
        masked_c = '0;
        hit_c    = 1'b0;
        gnt      = '0;
        gnt_id   = '0;
        for (int i = 0; i < 2 * int'(NREQ); i++) begin
            masked_c[i] = dbl_c[i] && (i >= int'(ptr));
        end
        for (int i = 0; i < 2 * int'(NREQ); i++) begin
            if (en && !hit_c && masked_c[i]) begin
                hit_c  = 1'b1;
                gnt_id = ARB_W'(i % int'(NREQ));
            end
        end
        if (hit_c) begin
            gnt[gnt_id] = 1'b1;
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder among NREQ requesters with round-robin grant and a single registered result slot.
module adder_arbiter
    import adder_arb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    adder_arbiter_if.slave  bus
);

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_nxt_c;
    logic [IDW-1:0]   gnt_id_c;
    logic [NREQ-1:0]  gnt_c;
    logic             slot_free_c;
    logic             xfer_c;
    logic [WIDTH-1:0] a_sel_c;
    logic [WIDTH-1:0] b_sel_c;
    logic [WIDTH:0]   full_sum_c;
    logic             rsp_valid_q;
    result_t          rsp_q;
    result_t          rsp_d_c;

    assign slot_free_c = !rsp_valid_q || bus.rsp_ready;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (bus.req_valid),
        .ptr    (ptr),
        .en     (slot_free_c),
        .gnt    (gnt_c),
        .gnt_id (gnt_id_c)
    );

    assign bus.req_ready = gnt_c;
    assign xfer_c        = |gnt_c;

    // Datapath: operand mux, widened add, result payload and next pointer.
    always_comb begin
        a_sel_c       = bus.req_a[int'(gnt_id_c) * int'(WIDTH) +: WIDTH];
        b_sel_c       = bus.req_b[int'(gnt_id_c) * int'(WIDTH) +: WIDTH];
        full_sum_c    = {1'b0, a_sel_c} + {1'b0, b_sel_c};
        rsp_d_c.id    = gnt_id_c;
        rsp_d_c.sum   = full_sum_c[WIDTH-1:0];
        rsp_d_c.cout  = full_sum_c[WIDTH];
        rsp_d_c.ovf   = add_ovf(a_sel_c, b_sel_c, full_sum_c[WIDTH-1:0]);
        ptr_nxt_c     = (int'(gnt_id_c) + 1 >= int'(NREQ)) ? '0 : IDW'(int'(gnt_id_c) + 1);
    end

    // Result slot: reload on transfer, otherwise drain on accept; data holds when not reloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            ptr         <= '0;
        end else if (xfer_c) begin
            rsp_valid_q <= 1'b1;
            rsp_q       <= rsp_d_c;
            ptr         <= ptr_nxt_c;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_q.id;
    assign bus.rsp_sum      = rsp_q.sum;
    assign bus.rsp_cout     = rsp_q.cout;
    assign bus.rsp_overflow = rsp_q.ovf;

endmodule
